// File: rtl/adt7320_scan_ctrl_if.sv
// Host register port and SPI engine port of the ADT7320 scan controller.
// The master modport is the scheduler's view; slave is the host/engine side.
interface adt7320_scan_ctrl_if;
    logic        host_req;
    logic        host_wr;
    logic [1:0]  host_chip;
    logic [2:0]  host_addr;
    logic        host_len16;
    logic [15:0] host_wdata;
    logic        host_ack;
    logic        host_done;
    logic [15:0] host_rdata;

    logic        eng_start;
    logic [1:0]  eng_chip;
    logic [7:0]  eng_cmd;
    logic        eng_len16;
    logic [15:0] eng_wdata;
    logic        eng_busy;
    logic        eng_done;
    logic [15:0] eng_rdata;

    modport master (
        input  host_req, host_wr, host_chip, host_addr, host_len16, host_wdata,
        output host_ack, host_done, host_rdata,
        output eng_start, eng_chip, eng_cmd, eng_len16, eng_wdata,
        input  eng_busy, eng_done, eng_rdata
    );

    modport slave (
        output host_req, host_wr, host_chip, host_addr, host_len16, host_wdata,
        input  host_ack, host_done, host_rdata,
        input  eng_start, eng_chip, eng_cmd, eng_len16, eng_wdata,
        output eng_busy, eng_done, eng_rdata
    );
endinterface

// File: rtl/adt7320_scan_ctrl.sv
// Shares one ADT7320 SPI engine between a periodic temperature poller and a
// host register port; configures every sensor after reset.
module adt7320_scan_ctrl #(
    parameter int         NCHIP       = 4,
    parameter int         POLL_CYCLES = 100000,
    parameter logic [7:0] CONFIG_VAL  = 8'h80
) (
    input  logic                 clk,
    input  logic                 reset,
    adt7320_scan_ctrl_if.master  bus,
    output logic [16*NCHIP-1:0]  temp_flat,
    output logic [NCHIP-1:0]     temp_valid,
    output logic                 init_done
);
    localparam int            TW          = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_MAX   = TW'(POLL_CYCLES - 1);
    localparam logic [1:0]    LAST_CHIP   = 2'(NCHIP - 1);
    localparam logic [7:0]    CMD_CFG_WR  = 8'h08;
    localparam logic [7:0]    CMD_TEMP_RD = 8'h50;

    typedef enum logic [2:0] {INIT_ISSUE, INIT_WAIT, IDLE, ISSUE, WAIT} state_t;

    state_t        state, state_nx;
    logic          issue_rdy;
    logic [1:0]    init_chip;
    logic [1:0]    poll_ptr;
    logic          poll_pending;
    logic          last_poll;
    logic          cur_host;
    logic          bad_chip;
    logic [TW-1:0] timer;
    logic          grant_host, grant_poll;
    logic          start, ack, poll_wr, host_bad;

    logic [1:0]    eng_chip_r;
    logic [7:0]    eng_cmd_r;
    logic          eng_len16_r;
    logic [15:0]   eng_wdata_r;
    logic          host_done_r;
    logic [15:0]   host_rdata_r;

    assign host_bad = int'(bus.host_chip) >= NCHIP;
    assign poll_wr  = (state == WAIT) && bus.eng_done && !cur_host;

    // On contention the side that did not win last time gets the engine.
    always_comb begin
        grant_host = 1'b0;
        grant_poll = 1'b0;
        if (bus.host_req && poll_pending) begin
            grant_host = last_poll;
            grant_poll = !last_poll;
        end else begin
            grant_host = bus.host_req;
            grant_poll = poll_pending;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= INIT_ISSUE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        ack      = 1'b0;
        unique case (state)
            INIT_ISSUE: begin
                if (issue_rdy && !bus.eng_busy) begin
                    start    = 1'b1;
                    state_nx = INIT_WAIT;
                end
            end
            INIT_WAIT: begin
                if (bus.eng_done) state_nx = (init_chip == LAST_CHIP) ? IDLE : INIT_ISSUE;
            end
            IDLE: begin
                if (grant_host || grant_poll) state_nx = ISSUE;
            end
            ISSUE: begin
                if (bad_chip) begin
                    ack      = 1'b1;
                    state_nx = IDLE;
                end else if (!bus.eng_busy) begin
                    start    = 1'b1;
                    ack      = cur_host;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (bus.eng_done) state_nx = IDLE;
            end
            default: state_nx = INIT_ISSUE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_rdy    <= 1'b0;
            init_chip    <= '0;
            poll_ptr     <= '0;
            poll_pending <= 1'b0;
            last_poll    <= 1'b1;
            cur_host     <= 1'b0;
            bad_chip     <= 1'b0;
            timer        <= '0;
            init_done    <= 1'b0;
            eng_chip_r   <= '0;
            eng_cmd_r    <= '0;
            eng_len16_r  <= 1'b0;
            eng_wdata_r  <= '0;
            host_done_r  <= 1'b0;
            host_rdata_r <= '0;
        end else begin
            host_done_r <= 1'b0;
            // A wrap during a pass finds poll_pending already set and is lost.
            if (init_done) begin
                timer <= (timer == TIMER_MAX) ? '0 : timer + 1'b1;
                if (timer == TIMER_MAX) poll_pending <= 1'b1;
            end
            case (state)
                INIT_ISSUE: begin
                    if (!issue_rdy) begin
                        eng_chip_r  <= init_chip;
                        eng_cmd_r   <= CMD_CFG_WR;
                        eng_len16_r <= 1'b0;
                        eng_wdata_r <= {8'h00, CONFIG_VAL};
                        issue_rdy   <= 1'b1;
                    end else if (start) begin
                        issue_rdy <= 1'b0;
                    end
                end
                INIT_WAIT: begin
                    if (bus.eng_done) begin
                        if (init_chip == LAST_CHIP) begin
                            init_done    <= 1'b1;
                            poll_pending <= 1'b1;
                        end else begin
                            init_chip <= init_chip + 2'd1;
                        end
                    end
                end
                IDLE: begin
                    if (grant_host) begin
                        eng_chip_r  <= bus.host_chip;
                        eng_cmd_r   <= {1'b0, ~bus.host_wr, bus.host_addr, 3'b000};
                        eng_len16_r <= bus.host_len16;
                        eng_wdata_r <= bus.host_wdata;
                        cur_host    <= 1'b1;
                        last_poll   <= 1'b0;
                        bad_chip    <= host_bad;
                        issue_rdy   <= 1'b1;
                    end else if (grant_poll) begin
                        eng_chip_r  <= poll_ptr;
                        eng_cmd_r   <= CMD_TEMP_RD;
                        eng_len16_r <= 1'b1;
                        eng_wdata_r <= '0;
                        cur_host    <= 1'b0;
                        last_poll   <= 1'b1;
                        bad_chip    <= 1'b0;
                        issue_rdy   <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (bad_chip) begin
                        host_done_r  <= 1'b1;
                        host_rdata_r <= 16'hFFFF;
                        issue_rdy    <= 1'b0;
                    end else if (start) begin
                        issue_rdy <= 1'b0;
                    end
                end
                WAIT: begin
                    if (bus.eng_done) begin
                        if (cur_host) begin
                            host_done_r  <= 1'b1;
                            host_rdata_r <= bus.eng_rdata;
                        end else if (poll_ptr == LAST_CHIP) begin
                            poll_ptr     <= '0;
                            poll_pending <= 1'b0;
                        end else begin
                            poll_ptr <= poll_ptr + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar k = 0; k < NCHIP; k++) begin : g_slot
        logic [15:0] temp;
        logic        valid;
        always_ff @(posedge clk) begin
            if (reset) begin
                temp  <= '0;
                valid <= 1'b0;
            end else if (poll_wr && poll_ptr == 2'(k)) begin
                temp  <= bus.eng_rdata;
                valid <= 1'b1;
            end
        end
        assign temp_flat[16*k +: 16] = temp;
        assign temp_valid[k]         = valid;
    end

    assign bus.eng_start  = start;
    assign bus.host_ack   = ack;
    assign bus.eng_chip   = eng_chip_r;
    assign bus.eng_cmd    = eng_cmd_r;
    assign bus.eng_len16  = eng_len16_r;
    assign bus.eng_wdata  = eng_wdata_r;
    assign bus.host_done  = host_done_r;
    assign bus.host_rdata = host_rdata_r;
endmodule

// File: tb/tb_adt7320_scan_ctrl.sv
// Directed bench for adt7320_scan_ctrl: a 4-chip instance with a model engine
// and a 3-chip instance for the out-of-range host chip case.
module tb_adt7320_scan_ctrl;
    localparam int P_A = 600;
    localparam int P_B = 2000;

    logic clk = 1'b0;
    logic reset_a, reset_b;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   init_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adt7320_scan_ctrl_if bus_a();
    adt7320_scan_ctrl_if bus_b();

    logic [63:0] temp_a;
    logic [3:0]  valid_a;
    logic        init_a;
    logic [47:0] temp_b;
    logic [2:0]  valid_b;
    logic        init_b;

    adt7320_scan_ctrl #(.NCHIP(4), .POLL_CYCLES(P_A), .CONFIG_VAL(8'h80)) dut_a (
        .clk(clk), .reset(reset_a), .bus(bus_a),
        .temp_flat(temp_a), .temp_valid(valid_a), .init_done(init_a));

    adt7320_scan_ctrl #(.NCHIP(3), .POLL_CYCLES(P_B), .CONFIG_VAL(8'h80)) dut_b (
        .clk(clk), .reset(reset_b), .bus(bus_b),
        .temp_flat(temp_b), .temp_valid(valid_b), .init_done(init_b));

    // Engine model A: done after lat_a cycles; host reads return host_resp,
    // poll reads return poll_base + chip.
    logic        ea_busy = 1'b0, ea_done = 1'b0, ea_host = 1'b0;
    logic [15:0] ea_rdata = '0;
    logic [1:0]  ea_chip = '0;
    int          ea_cnt = 0;
    int          lat_a = 40;
    logic [15:0] poll_base = 16'h0C80;
    logic [15:0] host_resp = 16'h1234;

    assign bus_a.eng_busy  = ea_busy;
    assign bus_a.eng_done  = ea_done;
    assign bus_a.eng_rdata = ea_rdata;

    always @(posedge clk) begin
        ea_done <= 1'b0;
        if (reset_a) begin
            ea_busy <= 1'b0;
            ea_cnt  <= 0;
        end else if (bus_a.eng_start) begin
            ea_busy <= 1'b1;
            ea_cnt  <= lat_a;
            ea_chip <= bus_a.eng_chip;
            ea_host <= bus_a.host_ack;
        end else if (ea_busy) begin
            if (ea_cnt <= 1) begin
                ea_busy  <= 1'b0;
                ea_done  <= 1'b1;
                ea_rdata <= ea_host ? host_resp : poll_base + {14'h0, ea_chip};
            end else begin
                ea_cnt <= ea_cnt - 1;
            end
        end
    end

    logic        eb_busy = 1'b0, eb_done = 1'b0;
    logic [15:0] eb_rdata = '0;
    logic [1:0]  eb_chip = '0;
    int          eb_cnt = 0;

    assign bus_b.eng_busy  = eb_busy;
    assign bus_b.eng_done  = eb_done;
    assign bus_b.eng_rdata = eb_rdata;

    always @(posedge clk) begin
        eb_done <= 1'b0;
        if (reset_b) begin
            eb_busy <= 1'b0;
            eb_cnt  <= 0;
        end else if (bus_b.eng_start) begin
            eb_busy <= 1'b1;
            eb_cnt  <= 5;
            eb_chip <= bus_b.eng_chip;
        end else if (eb_busy) begin
            if (eb_cnt <= 1) begin
                eb_busy  <= 1'b0;
                eb_done  <= 1'b1;
                eb_rdata <= 16'h0C80 + {14'h0, eb_chip};
            end else begin
                eb_cnt <= eb_cnt - 1;
            end
        end
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_a.eng_start, bus_a.host_ack, bus_a.host_done, init_a} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0000",
                     {bus_a.eng_start, bus_a.host_ack, bus_a.host_done, init_a});
        end
        checks++;
        if (bus_a.eng_cmd !== 8'h00 || bus_a.eng_wdata !== 16'h0000 || bus_a.host_rdata !== 16'h0000) begin
            failures++;
            $display("FAIL reset_fields cmd=%h wdata=%h rdata=%h exp all 0",
                     bus_a.eng_cmd, bus_a.eng_wdata, bus_a.host_rdata);
        end
        checks++;
        if (temp_a !== 64'h0 || valid_a !== 4'h0) begin
            failures++;
            $display("FAIL reset_temp temp=%h valid=%h exp 0/0", temp_a, valid_a);
        end
    endtask

    task automatic test_init();
        int n = 0;
        int dcyc = -10;
        bit early_ack = 1'b0;
        reset_a = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (init_a) break;
            if (ea_done) dcyc = cyc;
            if (bus_a.host_ack) early_ack = 1'b1;
            if (bus_a.eng_start) begin
                checks++;
                if (bus_a.eng_cmd !== 8'h08 || bus_a.eng_chip !== n[1:0] ||
                    bus_a.eng_wdata !== 16'h0080 || bus_a.eng_len16 !== 1'b0) begin
                    failures++;
                    $display("FAIL init_write%0d cmd=%h chip=%0d wdata=%h len16=%b exp 08/%0d/0080/0",
                             n, bus_a.eng_cmd, bus_a.eng_chip, bus_a.eng_wdata, bus_a.eng_len16, n);
                end
                n++;
            end
        end
        checks++;
        if (n !== 4) begin
            failures++;
            $display("FAIL init_count got=%0d exp=4", n);
        end
        checks++;
        if (init_a !== 1'b1 || cyc != dcyc + 1) begin
            failures++;
            $display("FAIL init_done_timing init=%b cyc=%0d exp 1 at %0d", init_a, cyc, dcyc + 1);
        end
        checks++;
        if (early_ack) begin
            failures++;
            $display("FAIL init_host_block got=ack exp=no ack before init_done");
        end
        init_cyc = cyc;
    endtask

    // host_req has been held since reset: chip 2, addr 2, 16-bit read.
    task automatic test_host_read();
        int d = 0;
        bit stable = 1'b1;
        bit seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (bus_a.host_ack || bus_a.eng_start) break;
            @(negedge clk);
        end
        checks++;
        if (bus_a.host_ack !== 1'b1 || bus_a.eng_start !== 1'b1 || cyc != init_cyc + 1) begin
            failures++;
            $display("FAIL host_ack_start ack=%b start=%b cyc=%0d exp 1/1 at %0d",
                     bus_a.host_ack, bus_a.eng_start, cyc, init_cyc + 1);
        end
        checks++;
        if (bus_a.eng_cmd !== 8'h50 || bus_a.eng_chip !== 2'd2 || bus_a.eng_len16 !== 1'b1) begin
            failures++;
            $display("FAIL host_fields cmd=%h chip=%0d len16=%b exp 50/2/1",
                     bus_a.eng_cmd, bus_a.eng_chip, bus_a.eng_len16);
        end
        bus_a.host_req = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (ea_done) begin
                seen = 1'b1;
                break;
            end
            if (bus_a.eng_cmd !== 8'h50 || bus_a.eng_chip !== 2'd2) stable = 1'b0;
        end
        d = cyc;
        checks++;
        if (!seen || !stable) begin
            failures++;
            $display("FAIL host_hold done_seen=%b stable=%b exp 1/1", seen, stable);
        end
        @(negedge clk);
        checks++;
        if (bus_a.host_done !== 1'b1 || bus_a.host_rdata !== 16'h1234) begin
            failures++;
            $display("FAIL host_done done=%b rdata=%h exp 1/1234", bus_a.host_done, bus_a.host_rdata);
        end
        for (int c = 0; c < 50; c++) begin
            if (bus_a.eng_start) break;
            @(negedge clk);
        end
        checks++;
        if (bus_a.eng_start !== 1'b1 || cyc < d + 2 || bus_a.host_ack !== 1'b0 ||
            bus_a.eng_cmd !== 8'h50 || bus_a.eng_chip !== 2'd0) begin
            failures++;
            $display("FAIL next_start start=%b cyc=%0d ack=%b cmd=%h chip=%0d exp poll chip0 at >=%0d",
                     bus_a.eng_start, cyc, bus_a.host_ack, bus_a.eng_cmd, bus_a.eng_chip, d + 2);
        end
    endtask

    task automatic test_poll();
        bit seen = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (valid_a == 4'hF) break;
        end
        checks++;
        if (valid_a !== 4'hF || temp_a !== 64'h0C83_0C82_0C81_0C80) begin
            failures++;
            $display("FAIL poll_pass1 valid=%h temp=%h exp F/0c830c820c810c80", valid_a, temp_a);
        end
        poll_base = 16'h0D00;
        for (int c = 0; c < P_A + 100; c++) begin
            @(negedge clk);
            if (bus_a.eng_start && !bus_a.host_ack && bus_a.eng_chip == 2'd0) begin
                seen = 1'b1;
                break;
            end
        end
        // Wrap lands P cycles after init_done; the engine start follows the IDLE decision.
        checks++;
        if (!seen || cyc != init_cyc + P_A + 1) begin
            failures++;
            $display("FAIL poll_period seen=%b cyc=%0d exp %0d", seen, cyc, init_cyc + P_A + 1);
        end
    endtask

    // Entered at the first poll start of pass 2; host then requests continuously.
    task automatic test_contention();
        int g = 1;
        int hosts = 0;
        int dones = 0;
        bit ok;
        bus_a.host_wr    = 1'b1;
        bus_a.host_chip  = 2'd1;
        bus_a.host_addr  = 3'd3;
        bus_a.host_len16 = 1'b0;
        bus_a.host_wdata = 16'hAB55;
        host_resp        = 16'h5A5A;
        bus_a.host_req   = 1'b1;
        for (int c = 0; c < 1500 && (g < 8 || dones < 4); c++) begin
            @(negedge clk);
            if (bus_a.host_done) begin
                dones++;
                checks++;
                if (bus_a.host_rdata !== 16'h5A5A) begin
                    failures++;
                    $display("FAIL contention_wr_rdata got=%h exp=5a5a", bus_a.host_rdata);
                end
            end
            if (bus_a.eng_start && g < 8) begin
                if (g % 2 == 1)
                    ok = bus_a.host_ack && bus_a.eng_cmd == 8'h18 && bus_a.eng_chip == 2'd1 &&
                         bus_a.eng_len16 == 1'b0 && bus_a.eng_wdata[7:0] == 8'h55;
                else
                    ok = !bus_a.host_ack && bus_a.eng_cmd == 8'h50 &&
                         bus_a.eng_chip == 2'(g / 2) && bus_a.eng_len16 == 1'b1;
                checks++;
                if (!ok) begin
                    failures++;
                    $display("FAIL contention_grant%0d ack=%b cmd=%h chip=%0d exp %s",
                             g, bus_a.host_ack, bus_a.eng_cmd, bus_a.eng_chip,
                             (g % 2 == 1) ? "host write chip1" : "poll");
                end
                if (bus_a.host_ack) begin
                    hosts++;
                    if (hosts == 4) bus_a.host_req = 1'b0;
                end
                g++;
            end
        end
        checks++;
        if (g != 8 || dones != 4) begin
            failures++;
            $display("FAIL contention_count grants=%0d dones=%0d exp 8/4", g, dones);
        end
        checks++;
        if (valid_a !== 4'hF || temp_a !== 64'h0D03_0D02_0D01_0D00) begin
            failures++;
            $display("FAIL contention_pass valid=%h temp=%h exp F/0d030d020d010d00", valid_a, temp_a);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        bit pre;
        for (int c = 0; c < 2 * P_A; c++) begin
            @(negedge clk);
            if (bus_a.eng_start && !bus_a.host_ack && bus_a.eng_chip == 2'd1) begin
                seen = 1'b1;
                break;
            end
        end
        repeat (5) @(negedge clk);
        pre = seen && init_a && (valid_a == 4'hF);
        reset_a = 1'b1;
        @(negedge clk);
        checks++;
        if (!pre || {bus_a.eng_start, bus_a.host_done, init_a} !== 3'b000 || valid_a !== 4'h0) begin
            failures++;
            $display("FAIL reset_mid pre=%b start=%b done=%b init=%b valid=%h exp 1/0/0/0/0",
                     pre, bus_a.eng_start, bus_a.host_done, init_a, valid_a);
        end
        checks++;
        if (temp_a !== 64'h0 || bus_a.host_rdata !== 16'h0000) begin
            failures++;
            $display("FAIL reset_mid_data temp=%h rdata=%h exp 0/0", temp_a, bus_a.host_rdata);
        end
        @(negedge clk);
        reset_a = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus_a.eng_start) break;
        end
        checks++;
        if (bus_a.eng_start !== 1'b1 || bus_a.eng_cmd !== 8'h08 || bus_a.eng_chip !== 2'd0 ||
            bus_a.eng_wdata !== 16'h0080) begin
            failures++;
            $display("FAIL reset_mid_restart start=%b cmd=%h chip=%0d wdata=%h exp 1/08/0/0080",
                     bus_a.eng_start, bus_a.eng_cmd, bus_a.eng_chip, bus_a.eng_wdata);
        end
    endtask

    task automatic test_invalid_chip();
        int writes = 0;
        bus_b.host_req = 1'b1;
        @(negedge clk);
        reset_b = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus_b.host_ack) break;
            if (bus_b.eng_start && bus_b.eng_cmd == 8'h08) writes++;
        end
        checks++;
        if (bus_b.host_ack !== 1'b1 || bus_b.eng_start !== 1'b0 || init_b !== 1'b1 || writes != 3) begin
            failures++;
            $display("FAIL bad_chip_ack ack=%b start=%b init=%b writes=%0d exp 1/0/1/3",
                     bus_b.host_ack, bus_b.eng_start, init_b, writes);
        end
        bus_b.host_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_b.host_done !== 1'b1 || bus_b.host_rdata !== 16'hFFFF || bus_b.eng_start !== 1'b0) begin
            failures++;
            $display("FAIL bad_chip_done done=%b rdata=%h start=%b exp 1/ffff/0",
                     bus_b.host_done, bus_b.host_rdata, bus_b.eng_start);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus_b.eng_start) break;
        end
        checks++;
        if (bus_b.eng_start !== 1'b1 || bus_b.host_ack !== 1'b0 || bus_b.eng_chip !== 2'd0 ||
            bus_b.eng_cmd !== 8'h50) begin
            failures++;
            $display("FAIL bad_chip_resume start=%b ack=%b chip=%0d cmd=%h exp 1/0/0/50",
                     bus_b.eng_start, bus_b.host_ack, bus_b.eng_chip, bus_b.eng_cmd);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d exp finish earlier", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_a          = 1'b1;
        reset_b          = 1'b1;
        bus_a.host_req   = 1'b1;
        bus_a.host_wr    = 1'b0;
        bus_a.host_chip  = 2'd2;
        bus_a.host_addr  = 3'd2;
        bus_a.host_len16 = 1'b1;
        bus_a.host_wdata = 16'h0000;
        bus_b.host_req   = 1'b0;
        bus_b.host_wr    = 1'b0;
        bus_b.host_chip  = 2'd3;
        bus_b.host_addr  = 3'd2;
        bus_b.host_len16 = 1'b1;
        bus_b.host_wdata = 16'h0000;
        test_reset();
        test_init();
        test_host_read();
        test_poll();
        test_contention();
        test_reset_mid();
        test_invalid_chip();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adt7320_scan_ctrl.md
# adt7320_scan_ctrl

Scheduler that shares one ADT7320 SPI transaction engine between an automatic temperature poller and a host register-access port. After reset it writes the configuration register of every sensor. It then reads the temperature register of each sensor once per poll period, interleaving host reads and writes with fair alternating priority. It sits between the board-level host register interface and the SPI engine, and holds the latest temperature of every chip.

## Interface
- NCHIP, 4: number of sensors; valid values are 1 to 4.
- POLL_CYCLES, 100000: poll period in clk cycles (1 ms at 100 MHz).
- CONFIG_VAL, 8'h80: byte written to configuration register (addr 1) of each chip at init (16-bit resolution).

Ports:
- clk  in  1  100 MHz master clock.
- reset  in  1  synchronous, active-high.
- host_req  in  1  host request; held high until host_ack.
- host_wr  in  1  1=write, 0=read.
- host_chip  in  2  target chip index.
- host_addr  in  3  ADT7320 register address.
- host_len16  in  1  1=16-bit data phase, 0=8-bit.
- host_wdata  in  16  write data; for 8-bit writes the low byte is used.
- host_ack  out  1  one-cycle pulse when the request is accepted; host inputs are sampled in this cycle.
- host_done  out  1  one-cycle pulse when the host transaction completes.
- host_rdata  out  16  read data, valid from host_done until the next host_done.
- eng_start  out  1  one-cycle start pulse to the SPI engine.
- eng_chip  out  2  chip-select index for the transaction.
- eng_cmd  out  8  command byte: {1'b0, rd, addr[2:0], 3'b000}; rd=1 for read.
- eng_len16  out  1  data-phase length.
- eng_wdata  out  16  data to shift out.
- eng_busy  in  1  engine busy.
- eng_done  in  1  one-cycle pulse at end of transaction.
- eng_rdata  in  16  read data; valid with eng_done, 8-bit reads zero-extended.
- temp_flat  out  16*NCHIP  latest temperature; chip k occupies bits [16k+15:16k].
- temp_valid  out  NCHIP  bit k set once chip k has been read since reset.
- init_done  out  1  set once all config writes have completed.

## Operation
- States:
  - INIT_ISSUE and INIT_WAIT: configuration writes.
  - IDLE: arbitration.
  - ISSUE: drive eng_start.
  - WAIT: wait for eng_done.
- Reset:
  - State goes to INIT_ISSUE; the init chip counter is cleared.
  - All outputs are 0, including temp_flat, temp_valid, host_rdata and init_done.
  - The poll timer is 0 and poll_pending=0.
  - The last-grant flag is set to "poll".
- Init sequence, for chip 0 to NCHIP-1:
  - Issue a write with eng_cmd=8'h08, eng_len16=0 and eng_wdata={8'h00, CONFIG_VAL}.
  - Wait for eng_done.
  - After the last chip: set init_done=1 and poll_pending=1 (first pass immediately), then go to IDLE.
  - host_req is not acknowledged before init_done.
- Poll timer:
  - Free-runs from init_done and wraps at POLL_CYCLES-1.
  - On wrap, poll_pending is set.
  - A wrap while a pass is in progress is dropped; there is no queueing.
- Poll pass:
  - One 16-bit read of addr 2 (eng_cmd=8'h50) per chip, chips 0 to NCHIP-1 in order.
  - The pass pointer advances per completed transaction.
  - poll_pending clears when the last chip completes.
- Arbitration in IDLE, at per-transaction granularity:
  - Only host_req set: grant host.
  - Only poll_pending set: grant poll.
  - Both set: grant the opposite of the last grant.
  - A poll grant blocked by a host grant resumes at the same pass pointer.
- Host grant:
  - host_ack is asserted in the same cycle as eng_start.
  - The request fields are latched into eng_* registers.
- Host grant with host_chip >= NCHIP:
  - host_ack is asserted, but there is no engine transaction.
  - host_done pulses on the next cycle with host_rdata=16'hFFFF.
- Completion, on eng_done in WAIT:
  - Poll: temp slot k <= eng_rdata and temp_valid[k] <= 1.
  - Host: host_rdata <= eng_rdata and host_done pulses. For host writes, host_rdata <= eng_rdata as well.
  - State returns to IDLE.
- ISSUE waits while eng_busy=1. eng_start is asserted only when eng_busy=0.
- eng_done outside WAIT or INIT_WAIT is ignored.

## Timing
- IDLE decision at cycle T: ISSUE at T+1, with eng_start, eng_* fields and (for host) host_ack registered high during T+1.
- eng_* fields hold stable from eng_start until eng_done.
- eng_done at cycle D:
  - State=IDLE, temp slot and host_rdata updated, and host_done high, all at D+1.
  - Next eng_start no earlier than D+2.
- Reset mid-transaction: eng_start drops at the next edge. The engine shares the same reset. No partial results are written.

## Test plan
- Init: after reset, with a model engine returning done after 40 cycles -> four writes, eng_cmd=8'h08, eng_wdata=16'h0080, chips 0..3 in order; init_done=1 after the 4th eng_done; host_req held throughout is not acknowledged until then.
- Poll: the engine returns 16'h0C80+chip -> temp_flat slots 0x0C80..0x0C83, temp_valid=4'hF; the next pass starts POLL_CYCLES after init_done.
- Contention: host_req held continuously during a pass -> grants alternate poll, host, poll, host; the pass completes after 4 poll transactions and no chip is skipped.
- Host read, chip 2, addr 2, 16-bit, engine returns 16'h1234 -> eng_cmd=8'h50, eng_chip=2; host_ack with eng_start; host_done one cycle after eng_done with host_rdata=16'h1234.
- Invalid chip: host_chip=3 with NCHIP=3 -> host_ack; no eng_start; host_done next cycle with host_rdata=16'hFFFF.
- Reset asserted in WAIT during a poll of chip 1 -> temp_valid=0, init_done=0, and the init sequence restarts at chip 0.
